ddr_read_fetcher: RTL

- Read-side initiator for the DDR controller's read port (read / readAddress / readAcknowledge / readData).
- Streams consecutive 16-bit words from a frame region of DDR into an internal FIFO.
- Serves those words to the VGA pixel pipeline one per pixel_req.
- Runs on the same clock as the controller.

---
 rtl/ddr_read_fetcher.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ddr_read_fetcher.sv
// Streams a DDR frame region into a small FIFO via a four-phase read handshake and serves pixels from it.
// Optional: define DDR_FETCH_UNDERFLOW_COUNT_EN to add a saturating underflow_count output.
module ddr_read_fetcher #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] FRAME_WORDS = 24'd307200,
  parameter int          FIFO_AW     = 4
) (
  input  logic               clk133_p,
  input  logic               rst,
  input  logic               frame_start,
  output logic               read,
  output logic [23:0]        readAddress,
  input  logic               readAcknowledge,
  input  logic [15:0]        readData,
  input  logic               pixel_req,
  output logic [15:0]        pixel_data,
  output logic               pixel_valid,
  output logic               underflow,
  output logic [FIFO_AW:0]   fifo_level
`ifdef DDR_FETCH_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]        underflow_count
`endif
);

  localparam int               DATA_W    = 16;
  localparam int               DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [23:0]      LAST_ADDR = BASE_ADDR + FRAME_WORDS - 24'd1;

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t                state;
  logic                  discard;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic                  push_p0;
  logic                  pop_p0;
  logic                  empty_req_p0;
  logic                  has_room;

  function automatic logic [23:0] next_addr(input logic [23:0] a);
    return (a == LAST_ADDR) ? BASE_ADDR : a + 24'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    has_room     = fifo_level < DEPTH_LVL;
    push_p0      = (state == REQ) && readAcknowledge && !discard && !frame_start;
    pop_p0       = pixel_req && (fifo_level != '0) && !frame_start;
    empty_req_p0 = pixel_req && (fifo_level == '0) && !frame_start;
  end

  // Handshake FSM: IDLE raises read, REQ waits for ack, RELEASE waits for ack to drop.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      read        <= 1'b0;
      readAddress <= BASE_ADDR;
      discard     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) readAddress <= BASE_ADDR;
          if (has_room && !readAcknowledge) begin
            read  <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (frame_start) discard <= 1'b1;
          if (readAcknowledge) begin
            read  <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!readAcknowledge) begin
            readAddress <= (discard || frame_start) ? BASE_ADDR : next_addr(readAddress);
            discard     <= 1'b0;
            state       <= IDLE;
          end else if (frame_start) begin
            discard <= 1'b1;
          end
        end
        default: begin
          read  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk133_p) begin
    if (push_p0) mem[wr_ptr] <= readData;
  end

  // FIFO control and pixel output stage; frame_start flushes and overrides any pixel_req.
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      underflow   <= 1'b0;
    end else if (frame_start) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      pixel_valid <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0) begin
        rd_ptr     <= rd_ptr + 1'b1;
        pixel_data <= mem[rd_ptr];
      end
      pixel_valid <= pop_p0;
      if (empty_req_p0) underflow <= 1'b1;
      fifo_level  <= fifo_level + (FIFO_AW + 1)'(push_p0) - (FIFO_AW + 1)'(pop_p0);
    end
  end

`ifdef DDR_FETCH_UNDERFLOW_COUNT_EN
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst)               underflow_count <= '0;
    else if (frame_start)   underflow_count <= '0;
    else if (empty_req_p0)  underflow_count <= sat_inc16(underflow_count);
  end
`else
  logic unused_sat;
  assign unused_sat = ^sat_inc16(16'h0);
`endif

endmodule
